// File: rtl/arb_sel_2to1_pkg.sv
// Shared encodings and the round-robin tie-break helper for arb_sel_2to1.
package arb_sel_2to1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  // A lone requester wins outright; otherwise the pointer decides.
  function automatic logic rr_winner(input logic v0, input logic v1, input logic prio);
    if (v0 && !v1) return SEL_IN0;
    if (v1 && !v0) return SEL_IN1;
    return prio;
  endfunction

endpackage

// File: rtl/mux_2to1.sv
// Single-bit 2:1 mux: Y follows I1 when S = 0, I2 when S = 1.
module mux_2to1 (
  input  logic I1,
  input  logic I2,
  input  logic S,
  output logic Y
);

  assign Y = S ? I2 : I1;

endmodule

// File: rtl/arb_sel_2to1.sv
// Two-input round-robin stream arbiter with registered output, one beat per cycle.
// Packet locking on `last` is built in only when ARB_PKT_LOCK_EN is defined.
module arb_sel_2to1
  import arb_sel_2to1_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel
);

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              sel_c;
  logic              load_en, gnt_vld, xfer;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W:0]   mux_a, mux_b, mux_y;

  assign mux_a = {in0_last, in0_data};
  assign mux_b = {in1_last, in1_data};

  for (genvar i = 0; i <= DATA_W; i++) begin : g_mux
    mux_2to1 u_mux (
      .I1 (mux_a[i]),
      .I2 (mux_b[i]),
      .S  (sel),
      .Y  (mux_y[i])
    );
  end

  always_comb begin
    sel_c = SEL_IN0;
    case (state_q)
      ST_IDLE:  sel_c = rr_winner(in0_valid, in1_valid, prio_q);
      ST_LOCK0: sel_c = SEL_IN0;
      ST_LOCK1: sel_c = SEL_IN1;
      default:  sel_c = SEL_IN0;
    endcase
  end

  // Grant is forced to in0 and both readies dropped while reset is held.
  assign sel       = rst ? SEL_IN0 : sel_c;
  assign load_en   = !out_valid_q || out_ready;
  assign gnt_vld   = (sel == SEL_IN1) ? in1_valid : in0_valid;
  assign xfer      = !rst && load_en && gnt_vld;
  assign in0_ready = !rst && load_en && (sel == SEL_IN0);
  assign in1_ready = !rst && load_en && (sel == SEL_IN1);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (xfer) begin
`ifdef ARB_PKT_LOCK_EN
      if (mux_y[DATA_W]) begin
        state_d = ST_IDLE;
        prio_d  = ~sel;
      end else begin
        state_d = (sel == SEL_IN1) ? ST_LOCK1 : ST_LOCK0;
      end
`else
      state_d = ST_IDLE;
      prio_d  = ~sel;
`endif
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load_en) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = mux_y[DATA_W-1:0];
        out_last_d = mux_y[DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_arb_sel_2to1.sv
// Scoreboard bench for arb_sel_2to1: sources drain per-port queues, the sink
// pops expected {last,data} beats in order; expectations follow ARB_PKT_LOCK_EN.
module tb_arb_sel_2to1;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in0_valid, in0_last, in0_ready;
  logic [DATA_W-1:0] in0_data;
  logic              in1_valid, in1_last, in1_ready;
  logic [DATA_W-1:0] in1_data;
  logic              out_valid, out_last, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              sel;

  logic [DATA_W:0] src0_q[$];
  logic [DATA_W:0] src1_q[$];
  logic [DATA_W:0] exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic            h0 = 1'b0;
  logic            h1 = 1'b0;
  logic [3:0]      b_sel, b_r1;

  always #5 clk = ~clk;

  arb_sel_2to1 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    in0_valid = (src0_q.size() != 0);
    {in0_last, in0_data} = (src0_q.size() != 0) ? src0_q[0] : '0;
    in1_valid = (src1_q.size() != 0);
    {in1_last, in1_data} = (src1_q.size() != 0) ? src1_q[0] : '0;
  endtask

  // Drive, then observe handshakes and the sink mid-cycle.
  task automatic sample();
    drive_inputs();
    @(negedge clk);
    h0 = in0_valid && in0_ready;
    h1 = in1_valid && in1_ready;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else chk("out_beat", {out_last, out_data}, exp_q.pop_front());
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (h0) void'(src0_q.pop_front());
    if (h1) void'(src1_q.pop_front());
    h0 = 1'b0;
    h1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    src0_q = {9'h111, 9'h111};
    src1_q = {9'h122, 9'h122};
    exp_q  = {9'h111, 9'h122, 9'h111, 9'h122};

    for (int k = 0; k < 2; k++) begin
      sample();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in0_ready", in0_ready, 0);
      chk("rst_in1_ready", in1_ready, 0);
      chk("rst_sel", sel, 0);
      advance();
    end
    rst = 1'b0;
    sample();
    chk("first_in0_ready", in0_ready, 1);
    chk("first_in1_ready", in1_ready, 0);
    chk("first_out_valid", out_valid, 0);

    // Tie with single-beat packets alternates every cycle.
    for (int k = 0; k < 4; k++) begin
      chk("tie_sel", sel, k % 2);
      advance();
      sample();
    end
    advance();
    sample();
    chk("tie_drain", exp_q.size(), 0);

    // Three-beat in0 packet competing with a single in1 beat.
    advance();
    src0_q = {9'h0A0, 9'h0A1, 9'h1A2};
    src1_q = {9'h1B0};
`ifdef ARB_PKT_LOCK_EN
    exp_q = {9'h0A0, 9'h0A1, 9'h1A2, 9'h1B0};
    b_sel = 4'b1000;
    b_r1  = 4'b1000;
`else
    exp_q = {9'h0A0, 9'h1B0, 9'h0A1, 9'h1A2};
    b_sel = 4'b0010;
    b_r1  = 4'b0010;
`endif
    sample();
    for (int k = 0; k < 4; k++) begin
      chk("pkt_sel", sel, b_sel[k]);
      chk("pkt_in1_ready", in1_ready, b_r1[k]);
      advance();
      sample();
    end
    advance();
    sample();
    chk("pkt_drain", exp_q.size(), 0);

    // Backpressure holds the output beat and both readies low.
    advance();
    src0_q = {9'h141, 9'h142, 9'h143};
    exp_q  = {9'h141, 9'h142, 9'h143};
    sample();
    chk("bp_first_ready", in0_ready, 1);
    advance();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 8'h41);
      chk("bp_in0_ready", in0_ready, 0);
      chk("bp_in1_ready", in1_ready, 0);
      advance();
    end
    out_ready = 1'b1;
    sample();
    advance();
    sample();
    chk("bp_next_valid", out_valid, 1);
    for (int k = 0; k < 2; k++) begin
      advance();
      sample();
    end
    chk("bp_drain", exp_q.size(), 0);

    // Reset in the middle of an in1 packet drops the lock and the held beat.
    advance();
    src1_q = {9'h0C0, 9'h0C1, 9'h0C2, 9'h1C3};
    exp_q  = {9'h0C0};
    sample();
    chk("mid_sel", sel, 1);
    advance();
    sample();
    advance();
    rst = 1'b1;
    src0_q = {9'h133};
    src1_q = {9'h1D0};
    exp_q.push_back(9'h133);
    exp_q.push_back(9'h1D0);
    sample();
    chk("mid_rst_in0_ready", in0_ready, 0);
    chk("mid_rst_in1_ready", in1_ready, 0);
    advance();
    rst = 1'b0;
    sample();
    chk("mid_out_valid", out_valid, 0);
    chk("mid_sel_after", sel, 0);
    chk("mid_in0_ready", in0_ready, 1);
    chk("mid_in1_ready", in1_ready, 0);
    for (int k = 0; k < 3; k++) begin
      advance();
      sample();
    end
    chk("mid_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
